// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM encoding and defaults.
// No logic of its own; imported by the arbiter and its round-robin picker.
// Default constants match the common 8-bit, 4-requester, 4-word-burst build.
package fifo_ctrl_pkg;

    // Arbiter FSM: IDLE arbitrates, BURST moves words, STALL waits out a full FIFO.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        STALL = 2'd2
    } arb_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set bit of req searching upward from ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_priority_picker
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       any_req
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] cur;
    logic             found;

    // Walk all NUM_REQ positions starting at ptr; the first requester seen wins.
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        cur     = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[cur]) begin
                found   = 1'b1;
                gnt_idx = cur;
            end
            cur = (cur == IDX_LAST) ? '0 : cur + 1'b1;
        end
        any_req = found;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter feeding one FIFO write port from NUM_REQ requesters in bursts.
// Latency: accepted word appears on wr_en/wrdata one clka cycle later; one idle cycle per grant.
// Backpressure: full drops req_ready combinationally and parks the FSM in STALL until it clears.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clka,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wrdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      rr_ptr_nxt;
    logic [IDX_W-1:0]      grant_nxt;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      rr_rot;
    logic [CNT_W-1:0]      burst_cnt;
    logic [CNT_W-1:0]      burst_cnt_nxt;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  pick_any;
    logic                  sel_valid;
    logic                  xfer;
    logic                  wr_en_nxt;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] wrdata_nxt;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .any_req (pick_any)
    );

    // Route the granted requester's valid and word; other requesters are ignored.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDX_W'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only the granted requester sees ready, and only while bursting into a non-full FIFO.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == BURST) && !full && (grant_id == IDX_W'(i));
        end
    end

    assign xfer    = (state == BURST) && !full && sel_valid;
    assign cnt_inc = burst_cnt + 1'b1;
    assign rr_rot  = (grant_id == IDX_LAST) ? '0 : grant_id + 1'b1;
    assign busy    = (state != IDLE);

    // Next-state and next-register values; burst completion outranks a stall.
    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        grant_nxt     = grant_id;
        burst_cnt_nxt = burst_cnt;
        wr_en_nxt     = xfer;
        wrdata_nxt    = xfer ? sel_data : wrdata;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_nxt     = pick_idx;
                    burst_cnt_nxt = '0;
                    state_nxt     = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    burst_cnt_nxt = cnt_inc;
                end
                if ((xfer && (cnt_inc == CNT_LAST)) || !sel_valid) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = rr_rot;
                end else if (full) begin
                    state_nxt = STALL;
                end
            end
            STALL: begin
                if (!sel_valid) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = rr_rot;
                end else if (!full) begin
                    state_nxt = BURST;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any word accepted in the reset cycle.
    always_ff @(posedge clka) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            grant_id  <= '0;
            wr_en     <= 1'b0;
            wrdata    <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
            grant_id  <= grant_nxt;
            wr_en     <= wr_en_nxt;
            wrdata    <= wrdata_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with default parameters (8-bit, 4 requesters, burst 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A data scoreboard checks every write strobe against the words handed over, in order.
module tb_fifo_wr_arbiter;
    import fifo_ctrl_pkg::*;

    logic        clka;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        full;
    logic        wr_en;
    logic [7:0]  wrdata;
    logic [1:0]  grant_id;
    logic        busy;

    fifo_wr_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .MAX_BURST  (4)
    ) dut (
        .clka      (clka),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .wr_en     (wr_en),
        .wrdata    (wrdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    int n_checks = 0;
    int n_errors = 0;
    int n_push   = 0;
    int n_wr     = 0;

    int         rem [4];
    logic [5:0] seq [4];
    logic [7:0] sb_q [$];

    logic       s_wr_en;
    logic [7:0] s_wrdata;
    logic [1:0] s_gid;
    logic       s_busy;
    logic [3:0] s_rdy;
    logic [1:0] s_state;
    logic [3:0] s_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Each requester offers rem[i] words tagged {i, seq}.
    task automatic apply_src();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (rem[i] != 0);
            req_data[i*8 +: 8] = {2'(i), seq[i]};
        end
    endtask

    // One clock cycle: sample at negedge, score, then advance sources after the edge.
    task automatic cyc();
        logic [7:0] exp_w;
        @(negedge clka);
        s_wr_en  = wr_en;
        s_wrdata = wrdata;
        s_gid    = grant_id;
        s_busy   = busy;
        s_rdy    = req_ready;
        s_state  = dut.state;
        if (wr_en === 1'b1) begin
            n_wr++;
            if (sb_q.size() == 0) begin
                check("sb_extra_write", 32'(1), 32'(0));
            end else begin
                exp_w = sb_q.pop_front();
                check("sb_data", 32'(wrdata), 32'(exp_w));
            end
        end
        s_acc = '0;
        if (reset) begin
            sb_q.delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    s_acc[i] = 1'b1;
                    sb_q.push_back(req_data[i*8 +: 8]);
                    n_push++;
                end
            end
        end
        @(posedge clka);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (s_acc[i]) begin
                rem[i]--;
                seq[i]++;
            end
        end
        apply_src();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        full  = 1'b0;
        for (int i = 0; i < 4; i++) rem[i] = 0;
        apply_src();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] busy_tab;
        logic [15:0] acc_tab;
        logic [11:0] rdy_tab;
        logic [11:0] wr_tab;
        logic [11:0] stall_tab;
        int          acc_cnt;
        int          rem_sum;

        reset = 1'b1;
        full  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0;
            seq[i] = '0;
        end
        apply_src();
        do_reset();

        // Reset state
        cyc();
        check("rst_wr_en",  32'(s_wr_en),  32'(0));
        check("rst_wrdata", 32'(s_wrdata), 32'(0));
        check("rst_gid",    32'(s_gid),    32'(0));
        check("rst_busy",   32'(s_busy),   32'(0));
        check("rst_ready",  32'(s_rdy),    32'(0));

        // All four streaming: grants 0,1,2,3,0, four words each, one idle cycle between
        do_reset();
        for (int i = 0; i < 4; i++) rem[i] = 8;
        apply_src();
        for (int n = 0; n < 5; n++) begin
            cyc();
            check("rr_idle_busy",  32'(s_busy),  32'(0));
            check("rr_idle_ready", 32'(s_rdy),   32'(0));
            check("rr_idle_wr_en", 32'(s_wr_en), 32'(n > 0));
            for (int j = 0; j < 4; j++) begin
                cyc();
                check("rr_gid",   32'(s_gid),   32'(n % 4));
                check("rr_ready", 32'(s_rdy),   32'(1 << (n % 4)));
                check("rr_wr_en", 32'(s_wr_en), 32'(j > 0));
            end
        end

        // Lone requester 2 with 10 words: bursts 4,4,2, last one ends on valid low
        do_reset();
        rem[2] = 10;
        apply_src();
        busy_tab = 16'h3BDE;
        acc_tab  = 16'h1BDE;
        for (int c = 0; c < 16; c++) begin
            cyc();
            check("lone_busy", 32'(s_busy),   32'(busy_tab[c]));
            check("lone_acc",  32'(s_acc[2]), 32'(acc_tab[c]));
            if (s_busy) check("lone_gid", 32'(s_gid), 32'(2));
        end

        // Full for 5 cycles after the 2nd word: STALL, then the burst completes at 4 words
        do_reset();
        rem[3] = 8;
        apply_src();
        rdy_tab   = 12'h606;
        wr_tab    = 12'hC0C;
        stall_tab = 12'h1F0;
        acc_cnt   = 0;
        for (int c = 0; c < 12; c++) begin
            full = (c >= 3 && c <= 7);
            cyc();
            check("stall_ready", 32'(s_rdy),   rdy_tab[c] ? 32'h8 : 32'h0);
            check("stall_wr_en", 32'(s_wr_en), 32'(wr_tab[c]));
            check("stall_state", 32'(s_state == STALL), 32'(stall_tab[c]));
            if (s_acc[3]) acc_cnt++;
        end
        full = 1'b0;
        check("stall_burst_len", 32'(acc_cnt), 32'(4));

        // Full rises right after the 4th word: exit to IDLE wins, pointer advances to 2
        do_reset();
        rem[1] = 8;
        rem[2] = 8;
        apply_src();
        for (int c = 0; c < 9; c++) begin
            full = (c == 5 || c == 6);
            cyc();
            if (c == 4) check("last_acc", 32'(s_acc[1]), 32'(1));
            if (c == 5) begin
                check("last_wr_en", 32'(s_wr_en), 32'(1));
                check("last_idle",  32'(s_state == IDLE), 32'(1));
            end
            if (c == 6) begin
                check("last_next_gid",   32'(s_gid), 32'(2));
                check("last_next_ready", 32'(s_rdy), 32'(0));
            end
            if (c == 7) check("last_then_stall", 32'(s_state == STALL), 32'(1));
            if (c == 8) check("last_resume_ready", 32'(s_rdy), 32'h4);
        end

        // Reset during the 3rd word of a burst from requester 1 (rr_ptr was 3)
        do_reset();
        rem[1] = 8;
        rem[2] = 4;
        apply_src();
        for (int c = 0; c < 13; c++) begin
            cyc();
            if (c == 4)  check("mid_gid_a", 32'(s_gid), 32'(1));
            if (c == 6)  check("mid_gid_b", 32'(s_gid), 32'(2));
            if (c == 11) check("mid_gid_c", 32'(s_gid), 32'(1));
        end
        reset = 1'b1;
        cyc();
        check("mid_prev_word", 32'(s_wr_en), 32'(1));
        reset  = 1'b0;
        rem[3] = 4;
        apply_src();
        cyc();
        check("mid_rst_wr_en",  32'(s_wr_en),  32'(0));
        check("mid_rst_busy",   32'(s_busy),   32'(0));
        check("mid_rst_gid",    32'(s_gid),    32'(0));
        check("mid_rst_ready",  32'(s_rdy),    32'(0));
        check("mid_rst_wrdata", 32'(s_wrdata), 32'(0));
        cyc();
        check("mid_regrant_gid",   32'(s_gid), 32'(1));
        check("mid_regrant_ready", 32'(s_rdy), 32'h2);

        // Drain and confirm nothing lost or duplicated
        for (int c = 0; c < 30; c++) cyc();
        rem_sum = 0;
        for (int i = 0; i < 4; i++) rem_sum += rem[i];
        check("sb_empty",   32'(sb_q.size()), 32'(0));
        check("sb_count",   32'(n_wr),        32'(n_push));
        check("src_drained", 32'(rem_sum),    32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
